// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front end for the 8-bit combinational ALU: collects opcode and
// operands, drives the ALU with registered controls, and returns one result per command.
module alu_cmd_sequencer #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] DIV0_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_mode,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_f,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [2:0] {OPC, OPA, OPB, EXEC, RESP} state_t;

    state_t state_reg;
    logic   in_xfer;
    logic   is_unary;
    logic   is_div0;

    // Gated by rst_n so the host sees no acceptance while reset is held.
    assign in_ready = rst_n && (state_reg == OPC || state_reg == OPA || state_reg == OPB);
    assign in_xfer  = in_valid && in_ready;
    assign is_unary = !alu_mode && (alu_op == 2'b11);
    assign is_div0  = alu_mode && (alu_op == 2'b10) && (alu_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= OPC;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= 1'b0;
            alu_op    <= 2'b00;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state_reg)
                OPC: begin
                    if (in_xfer) begin
                        alu_mode <= in_data[2];
                        alu_op   <= in_data[1:0];
                        alu_b    <= '0;
                        // Malformed opcode is answered at once; no operand bytes are taken.
                        if (|in_data[WIDTH-1:3]) begin
                            res_data  <= '0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            state_reg <= OPA;
                        end
                    end
                end
                OPA: begin
                    if (in_xfer) begin
                        alu_a     <= in_data;
                        state_reg <= is_unary ? EXEC : OPB;
                    end
                end
                OPB: begin
                    if (in_xfer) begin
                        alu_b     <= in_data;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_div0) begin
                        res_data <= DIV0_VAL;
                        res_err  <= 1'b1;
                    end else begin
                        res_data <= alu_f;
                        res_err  <= 1'b0;
                    end
                    res_valid <= 1'b1;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= OPC;
                    end
                end
                default: state_reg <= OPC;
            endcase
        end
    end

endmodule
